// File: rtl/scope_capture_ctrl.sv
// Capture sequencer for the flash-ADC scope front end.
// Waits for the sample FIFO to drain, arms a level/slope trigger (or an auto
// timeout), then writes one post-trigger record of programmable length with
// optional decimation, followed by a holdoff period.
module scope_capture_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LEN_W   = 10,
    parameter int unsigned AUTO_TO = 1048576,
    parameter int unsigned HOLD_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic [LEN_W-1:0]  capture_len,
    input  logic [7:0]        decim,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    output logic              wrreq,
    output logic [DATA_W-1:0] wr_data,
    output logic              triggered,
    output logic              forced,
    output logic              capture_done,
    output logic              busy,
    output logic [2:0]        state
);

    // Auto timer only has to reach AUTO_TO-1.
    localparam int unsigned TIMER_W = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;

    localparam logic [1:0] ModeNormal = 2'd0;
    localparam logic [1:0] ModeAuto   = 2'd1;
    localparam logic [1:0] ModeSingle = 2'd2;
    localparam logic [1:0] ModeStop   = 2'd3;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaitEmpty = 3'd1,
        StArmed     = 3'd2,
        StCapture   = 3'd3,
        StHoldoff   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                wrreq_q, wrreq_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                triggered_q, triggered_d;
    logic                forced_q, forced_d;
    logic                capture_done_q, capture_done_d;
    logic [LEN_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [7:0]          dec_cnt_q, dec_cnt_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;

    logic                dec_tick;
    logic [LEN_W-1:0]    len_eff;
    logic                rise_hit;
    logic                fall_hit;
    logic                trig_hit;
    logic                auto_hit;

    // Trigger detection, decimation tick and effective record length.
    always_comb begin
        dec_tick = (dec_cnt_q == 8'd0);
        len_eff  = (capture_len == '0) ? LEN_W'(1) : capture_len;
        rise_hit = prev_valid_q && (prev_q < trig_level) && (adc_data >= trig_level);
        fall_hit = prev_valid_q && (prev_q > trig_level) && (adc_data <= trig_level);
        trig_hit = dec_tick && (trig_rising ? rise_hit : fall_hit);
        auto_hit = (mode == ModeAuto) && (timer_q == TIMER_W'(AUTO_TO - 1));
    end

    // Next-state and registered-output logic for the capture sequencer.
    always_comb begin
        state_d        = state_q;
        wrreq_d        = 1'b0;
        wr_data_d      = wr_data_q;
        triggered_d    = triggered_q;
        forced_d       = forced_q;
        capture_done_d = 1'b0;
        sample_cnt_d   = sample_cnt_q;
        hold_cnt_d     = hold_cnt_q;
        timer_d        = timer_q;
        prev_d         = prev_q;
        prev_valid_d   = prev_valid_q;
        dec_cnt_d      = (dec_cnt_q >= decim) ? 8'd0 : dec_cnt_q + 8'd1;

        case (state_q)
            StIdle: begin
                if ((mode == ModeNormal) || (mode == ModeAuto) ||
                    ((mode == ModeSingle) && arm)) begin
                    state_d     = StWaitEmpty;
                    triggered_d = 1'b0;
                    forced_d    = 1'b0;
                end
            end
            StWaitEmpty: begin
                if (fifo_empty) begin
                    state_d      = StArmed;
                    timer_d      = '0;
                    prev_valid_d = 1'b0;
                    dec_cnt_d    = 8'd0;
                end
            end
            StArmed: begin
                if (dec_tick) begin
                    prev_d       = adc_data;
                    prev_valid_d = 1'b1;
                end
                if (mode == ModeAuto) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
                // A real edge wins over the timeout in the same clock.
                if (trig_hit || auto_hit) begin
                    state_d      = StCapture;
                    triggered_d  = trig_hit;
                    forced_d     = !trig_hit;
                    wrreq_d      = !fifo_full;
                    wr_data_d    = adc_data;
                    sample_cnt_d = LEN_W'(1);
                end
            end
            StCapture: begin
                if (sample_cnt_q >= len_eff) begin
                    capture_done_d = 1'b1;
                    state_d        = StHoldoff;
                    hold_cnt_d     = '0;
                end else if (dec_tick) begin
                    // A full FIFO drops the sample but the record keeps its length.
                    wrreq_d      = !fifo_full;
                    wr_data_d    = adc_data;
                    sample_cnt_d = sample_cnt_q + LEN_W'(1);
                end
            end
            StHoldoff: begin
                if (hold_cnt_q >= holdoff) begin
                    state_d = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Stop abandons whatever is in flight; a partial record stays in the FIFO.
        if (mode == ModeStop) begin
            state_d        = StIdle;
            wrreq_d        = 1'b0;
            capture_done_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            wrreq_q        <= 1'b0;
            wr_data_q      <= '0;
            triggered_q    <= 1'b0;
            forced_q       <= 1'b0;
            capture_done_q <= 1'b0;
            sample_cnt_q   <= '0;
            hold_cnt_q     <= '0;
            timer_q        <= '0;
            dec_cnt_q      <= 8'd0;
            prev_q         <= '0;
            prev_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            wrreq_q        <= wrreq_d;
            wr_data_q      <= wr_data_d;
            triggered_q    <= triggered_d;
            forced_q       <= forced_d;
            capture_done_q <= capture_done_d;
            sample_cnt_q   <= sample_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            timer_q        <= timer_d;
            dec_cnt_q      <= dec_cnt_d;
            prev_q         <= prev_d;
            prev_valid_q   <= prev_valid_d;
        end
    end

    assign wrreq        = wrreq_q;
    assign wr_data      = wr_data_q;
    assign triggered    = triggered_q;
    assign forced       = forced_q;
    assign capture_done = capture_done_q;
    assign busy         = (state_q != StIdle);
    assign state        = state_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Testbench for scope_capture_ctrl: a procedural reference model predicts every
// FIFO write and capture_done pulse; a monitor pops and compares them.
module tb_scope_capture_ctrl;

    localparam int AUTO_TO = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] adc_data;
    logic [7:0] trig_level;
    logic       trig_rising;
    logic [1:0] mode;
    logic       arm;
    logic [9:0] capture_len;
    logic [7:0] decim;
    logic [15:0] holdoff;
    logic       fifo_empty;
    logic       fifo_full;
    logic       wrreq;
    logic [7:0] wr_data;
    logic       triggered;
    logic       forced;
    logic       capture_done;
    logic       busy;
    logic [2:0] state;

    scope_capture_ctrl #(
        .DATA_W (8),
        .LEN_W  (10),
        .AUTO_TO(AUTO_TO),
        .HOLD_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adc_data    (adc_data),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .mode        (mode),
        .arm         (arm),
        .capture_len (capture_len),
        .decim       (decim),
        .holdoff     (holdoff),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .wrreq       (wrreq),
        .wr_data     (wr_data),
        .triggered   (triggered),
        .forced      (forced),
        .capture_done(capture_done),
        .busy        (busy),
        .state       (state)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
        bit         trig;
        bit         frc;
    } wr_t;

    wr_t  exp_wr[$];
    wr_t  exp_done[$];
    wr_t  mon_it;
    int   exp_state = 0;
    int   edges = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    bit   rnd_en = 0;
    int   pat = 0;
    logic [7:0] step8 = 8'd1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, edges);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_trig, m_frc, m_ab, m_go, m_fin, m_tk, m_pv;
    int         m_k, m_timer, m_cnt, m_h, m_len;
    logic [7:0] m_prev, m_cur;

    function automatic bit m_abort();
        return (!rst_n) || (mode == 2'd3);
    endfunction

    // Called at an edge; the write becomes visible during the following cycle.
    task automatic expect_write(input logic [7:0] d);
        wr_t it;
        if (!fifo_full) begin
            it.data = d; it.cyc = edges + 1; it.trig = m_trig; it.frc = m_frc;
            exp_wr.push_back(it);
        end
    endtask

    initial begin : ref_model
        forever begin
            m_go = 0;
            while (!m_go) begin
                @(posedge clk);
                m_go = rst_n && ((mode == 2'd0) || (mode == 2'd1) || ((mode == 2'd2) && arm));
                exp_state = m_go ? 1 : 0;
            end
            m_trig = 0; m_frc = 0; m_ab = 0; m_fin = 0;
            while (!m_fin) begin
                @(posedge clk);
                if (m_abort()) begin m_ab = 1; m_fin = 1; exp_state = 0; end
                else if (fifo_empty) begin m_fin = 1; exp_state = 2; end
            end
            if (!m_ab) begin
                m_k = 0; m_pv = 0; m_timer = 0; m_fin = 0;
                while (!m_fin) begin
                    @(posedge clk);
                    if (m_abort()) begin m_ab = 1; m_fin = 1; exp_state = 0; end
                    else begin
                        m_tk = (m_k % (int'(decim) + 1)) == 0;
                        m_k++;
                        m_cur = adc_data;
                        if (m_tk && m_pv && (trig_rising ?
                                (m_prev < trig_level && m_cur >= trig_level) :
                                (m_prev > trig_level && m_cur <= trig_level))) begin
                            m_trig = 1; m_fin = 1;
                        end else if (mode == 2'd1 && m_timer == AUTO_TO - 1) begin
                            m_frc = 1; m_fin = 1;
                        end else begin
                            if (mode == 2'd1) m_timer++;
                            if (m_tk) begin m_prev = m_cur; m_pv = 1; end
                        end
                        if (m_fin) begin expect_write(m_cur); exp_state = 3; end
                    end
                end
            end
            if (!m_ab) begin
                m_cnt = 1; m_fin = 0;
                while (!m_fin) begin
                    @(posedge clk);
                    if (m_abort()) begin m_ab = 1; m_fin = 1; exp_state = 0; end
                    else begin
                        m_tk = (m_k % (int'(decim) + 1)) == 0;
                        m_k++;
                        m_len = (capture_len == 0) ? 1 : int'(capture_len);
                        if (m_cnt >= m_len) begin
                            mon_it.data = 0; mon_it.cyc = edges + 1;
                            mon_it.trig = m_trig; mon_it.frc = m_frc;
                            exp_done.push_back(mon_it);
                            exp_state = 4; m_fin = 1;
                        end else begin
                            if (m_tk) begin expect_write(adc_data); m_cnt++; end
                            exp_state = 3;
                        end
                    end
                end
            end
            if (!m_ab) begin
                m_h = 0; m_fin = 0;
                while (!m_fin) begin
                    @(posedge clk);
                    if (m_abort()) begin m_fin = 1; exp_state = 0; end
                    else if (m_h >= int'(holdoff)) begin m_fin = 1; exp_state = 0; end
                    else begin m_h++; exp_state = 4; end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    wr_t mon_w;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("state", int'(state), exp_state);
            chk("busy", int'(busy), int'(exp_state != 0));
            if (wrreq) begin
                if (exp_wr.size() == 0) chk("wrreq_unexpected", int'(wrreq), 0);
                else begin
                    mon_w = exp_wr.pop_front();
                    chk("wr_data", int'(wr_data), int'(mon_w.data));
                    chk("wr_cycle", edges, mon_w.cyc);
                    chk("wr_triggered", int'(triggered), int'(mon_w.trig));
                    chk("wr_forced", int'(forced), int'(mon_w.frc));
                end
            end
            if (capture_done) begin
                if (exp_done.size() == 0) chk("done_unexpected", int'(capture_done), 0);
                else begin
                    mon_w = exp_done.pop_front();
                    chk("done_cycle", edges, mon_w.cyc);
                    chk("done_triggered", int'(triggered), int'(mon_w.trig));
                    chk("done_forced", int'(forced), int'(mon_w.frc));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            case (pat)
                1: adc_data = adc_data + step8;
                2: adc_data = 8'($urandom);
                default: ;
            endcase
            if (rnd_en) begin
                fifo_full  = ($urandom_range(0, 7) == 0);
                fifo_empty = ($urandom_range(0, 3) != 0);
                arm        = (mode == 2'd2) && ($urandom_range(0, 19) == 0);
            end
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick_n(1);
        arm = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wrreq"}, int'(wrreq), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
        chk({tag, "_triggered"}, int'(triggered), 0);
        chk({tag, "_forced"}, int'(forced), 0);
        chk({tag, "_capture_done"}, int'(capture_done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_state"}, int'(state), 0);
    endtask

    // Called at posedge+2; asserts reset mid-cycle and holds it over two edges.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        exp_wr.delete();
        exp_done.delete();
        exp_state = 0;
        mode = 2'd3;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic setup(input bit rise, input logic [7:0] lvl, input logic [7:0] dec,
                         input logic [9:0] len, input logic [15:0] hold);
        trig_rising = rise; trig_level = lvl; decim = dec;
        capture_len = len; holdoff = hold;
        fifo_empty = 1'b1; fifo_full = 1'b0; arm = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; mode = 2'd3; arm = 1'b0; adc_data = 8'h00;
        setup(1'b1, 8'h80, 8'd0, 10'd4, 16'd0);
        tick_n(3);
        rst_n = 1'b1;
        tick_n(1);
        #1;
        check_reset_outputs("reset");
        mon_en = 1;

        // Normal, rising ramp through 0x80.
        setup(1'b1, 8'h80, 8'd0, 10'd4, 16'd0);
        adc_data = 8'h7C; pat = 1; step8 = 8'd1; mode = 2'd0;
        tick_n(30);
        mode = 2'd3; tick_n(4);

        // Falling, decimated by 3.
        setup(1'b0, 8'h40, 8'd2, 10'd3, 16'd0);
        adc_data = 8'h50; pat = 1; step8 = 8'hFE; mode = 2'd0;
        tick_n(30);
        mode = 2'd3; tick_n(4);

        // Auto mode on a flat input.
        setup(1'b1, 8'h80, 8'd0, 10'd3, 16'd2);
        adc_data = 8'h10; pat = 0; mode = 2'd1;
        tick_n(60);
        mode = 2'd3; tick_n(4);

        // Single shot: idle until armed, one record per arm.
        setup(1'b1, 8'h80, 8'd0, 10'd2, 16'd1);
        adc_data = 8'h00; pat = 1; step8 = 8'h10; mode = 2'd2;
        tick_n(10);
        arm_pulse(); tick_n(40);
        arm_pulse(); tick_n(40);
        mode = 2'd3; tick_n(4);

        // FIFO full during the 2nd and 3rd writes of a 5-sample record.
        setup(1'b1, 8'h80, 8'd0, 10'd5, 16'd0);
        adc_data = 8'h7C; pat = 1; step8 = 8'd1; mode = 2'd0;
        tick_n(5);
        fifo_full = 1'b1; tick_n(2);
        fifo_full = 1'b0; tick_n(8);
        mode = 2'd3; tick_n(4);

        // FIFO never drains: parked in WAIT_EMPTY.
        fifo_empty = 1'b0; mode = 2'd0;
        tick_n(50);
        #1;
        chk("wait_empty_hold", int'(state), 1);
        mode = 2'd3; tick_n(2);
        fifo_empty = 1'b1;

        // Stop in the middle of a capture.
        setup(1'b1, 8'h80, 8'd0, 10'd20, 16'd0);
        adc_data = 8'h7C; pat = 1; step8 = 8'd1; mode = 2'd0;
        tick_n(8);
        mode = 2'd3;
        tick_n(1);
        #1;
        chk("stop_wrreq", int'(wrreq), 0);
        chk("stop_state", int'(state), 0);
        tick_n(4);

        // Reset in the middle of a capture.
        adc_data = 8'h7C; mode = 2'd0;
        tick_n(8);
        do_reset();
        tick_n(1);
        #1;
        check_reset_outputs("post_reset");

        // Randomized configurations and traffic.
        for (int it = 0; it < 8; it++) begin
            setup(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 3)),
                  10'($urandom_range(0, 8)), 16'($urandom_range(0, 5)));
            pat = 2; mode = 2'($urandom_range(0, 2)); rnd_en = 1;
            tick_n(150);
            rnd_en = 0; arm = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1; mode = 2'd3;
            tick_n(3);
        end

        tick_n(2);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scope_capture_ctrl.md
Name: scope_capture_ctrl

Overview:
Capture sequencer for the flash-ADC oscilloscope front end. It runs in the ADC sample clock domain and drives the write side of the sample FIFO. It waits for the FIFO to drain, arms a level/slope trigger, then writes one post-trigger record of programmable length with optional decimation. Supported modes are normal, auto (forced trigger on timeout), single-shot and stop. The FIFO read side and the UART transmitter are outside this block.

Parameters:
DATA_W, 8, sample width
LEN_W, 10, width of capture length and sample counter
AUTO_TO, 1048576, clocks without a trigger before auto mode forces one
HOLD_W, 16, width of holdoff counter

Ports:
clk  in  1  ADC sample clock
rst_n  in  1  asynchronous active-low reset
adc_data  in  DATA_W  registered ADC sample, one per clk
trig_level  in  DATA_W  trigger threshold, unsigned
trig_rising  in  1  1=rising-edge trigger, 0=falling-edge trigger
mode  in  2  0=normal, 1=auto, 2=single, 3=stop
arm  in  1  one-clk pulse; starts one capture in single mode
capture_len  in  LEN_W  samples per record; 0 is treated as 1
decim  in  8  keep one sample every decim+1 clocks
holdoff  in  HOLD_W  idle clocks after each record
fifo_empty  in  1  FIFO write-side empty flag
fifo_full  in  1  FIFO write-side full flag
wrreq  out  1  FIFO write request, registered
wr_data  out  DATA_W  FIFO write data, registered, valid when wrreq=1
triggered  out  1  1 if the current/last record came from a real trigger edge
forced  out  1  1 if the current/last record came from the auto timeout
capture_done  out  1  one-clk pulse at the end of each record
busy  out  1  1 in any state other than IDLE
state  out  3  current state code, for debug

Behaviour:
- Reset values: state=IDLE, wrreq=0, wr_data=0, triggered=0, forced=0, capture_done=0, all counters 0, prev-sample-valid=0.
- Decimation tick: an 8-bit counter that wraps at decim and is cleared on entry to ARMED. A tick occurs when the counter is 0. With decim=0, every clk is a tick.
- IDLE (0): mode 0 or 1 -> WAIT_EMPTY. Mode 2 -> WAIT_EMPTY only on arm=1. Mode 3 -> stay. Leaving IDLE clears triggered and forced.
- WAIT_EMPTY (1): when fifo_empty=1 -> ARMED, clearing the auto timer and prev-sample-valid.
- ARMED (2): on each tick, store the sample in prev and set prev-sample-valid.
  - Rising trigger: valid, prev<trig_level, cur>=trig_level.
  - Falling trigger: valid, prev>trig_level, cur<=trig_level.
  - Comparisons are unsigned.
  - The first tick after entry can never trigger.
  - On trigger: set triggered=1, go to CAPTURE, and write the triggering sample.
  - Auto timer: counts every clk in ARMED, in mode 1 only. When it reaches AUTO_TO-1 with no trigger, set forced=1, go to CAPTURE, and write the current adc_data. A real trigger in the same clk takes priority (triggered=1, forced=0).
- CAPTURE (3): wrreq=1 with wr_data=sample on each tick. Latency is one clk from sample to wrreq/wr_data.
  - The trigger sample is count 1.
  - After count reaches max(capture_len,1): pulse capture_done, go to HOLDOFF.
  - If fifo_full=1, wrreq is suppressed for that tick, the sample is dropped, the count still advances, and the record ends on schedule.
  - wrreq is never asserted while fifo_full=1 is sampled.
- HOLDOFF (4): count holdoff clks, then go to IDLE. holdoff=0 goes to IDLE the next clk. In single mode, IDLE then waits for a new arm.
- Stop: mode=3 in any state -> IDLE on the next clk. wrreq=0 from that clk on; no capture_done pulse; a partial record stays in the FIFO.
- arm outside IDLE, or outside mode 2, is ignored.
- Changes to trig_level, capture_len, decim or holdoff mid-record take effect at the next comparison or count; software changes them only in IDLE.
- Mode 0 never forces a trigger.

Test Plan:
- Normal, rising, level=0x80, decim=0, len=4, fifo_empty=1, ramp 0x7C..0x8F (+1/clk) -> wrreq for exactly 4 clks, wr_data 0x80,0x81,0x82,0x83, starting 1 clk after 0x80 is presented; triggered=1; capture_done pulse in the clk after the 4th write.
- Falling, level=0x40, decim=2, len=3, samples descending 2/clk from 0x50 -> writes are 3 clks apart and begin with the first ticked sample <=0x40, followed by the next two ticked samples; no writes between ticks.
- Auto mode, constant input 0x10, AUTO_TO=16 (bench override) -> forced=1 and first wrreq exactly 16 clks after entering ARMED; triggered=0.
- Single mode, len=2: no activity until arm pulse; one record; then stays IDLE with busy=0 despite further trigger edges; a second arm produces one more record.
- fifo_full=1 during the 2nd and 3rd writes of a len=5 record -> only 3 wrreq pulses, capture_done still on schedule; fifo_empty held 0 -> the block stays in WAIT_EMPTY indefinitely.
- mode=3 mid-CAPTURE and rst_n low mid-record -> wrreq=0 the next clk (stop) or immediately (reset), state=IDLE, no capture_done, all outputs at reset values after reset.
